// File: rtl/attack_anim_ctrl.sv
// Attack animation sequencer: draw, wait for a frame tick, erase, step one pixel,
// bouncing the sprite between START_X and TURN_X for NUM_FRAMES draws.
module attack_anim_ctrl #(
   parameter logic [8:0] START_X    = 9'd65,
   parameter logic [8:0] TURN_X     = 9'd90,
   parameter logic [7:0] START_Y    = 8'd93,
   parameter logic [5:0] NUM_FRAMES = 6'd50
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       frame_tick,
   input  logic       done_draw,
   output logic       busy,
   output logic       enable_draw,
   output logic       enable_erase,
   output logic [8:0] pos_x,
   output logic [7:0] pos_y,
   output logic [5:0] frame_count,
   output logic       done
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      DRAW       = 3'd1,
      WAIT_FRAME = 3'd2,
      ERASE      = 3'd3,
      MOVE       = 3'd4,
      FINISH     = 3'd5
   } state_e;

   state_e     state_q, state_d;
   logic [8:0] pos_x_q, pos_x_d;
   logic       dir_left_q, dir_left_d;
   logic [5:0] frame_count_q, frame_count_d;
   logic       tick_pending_q, tick_pending_d;
   logic [8:0] move_x_s;
   logic       busy_q, enable_draw_q, enable_erase_q, done_q;

   // Next-state, position, direction, frame counter and pending-tick logic
   always_comb begin
      state_d        = state_q;
      pos_x_d        = pos_x_q;
      dir_left_d     = dir_left_q;
      frame_count_d  = frame_count_q;
      tick_pending_d = tick_pending_q;

      // Step right only while below the turn point; anything else steps left,
      // so pos_x cannot escape the [START_X, TURN_X] window.
      if ((!dir_left_q && (pos_x_q < TURN_X)) || (pos_x_q <= START_X)) begin
         move_x_s = pos_x_q + 9'd1;
      end else begin
         move_x_s = pos_x_q - 9'd1;
      end

      if (((state_q == DRAW) || (state_q == ERASE) || (state_q == MOVE)) && frame_tick) begin
         tick_pending_d = 1'b1;
      end else begin
         tick_pending_d = tick_pending_q;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d        = DRAW;
               pos_x_d        = START_X;
               dir_left_d     = 1'b0;
               frame_count_d  = 6'd0;
               tick_pending_d = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         DRAW: begin
            if (done_draw) begin
               frame_count_d = frame_count_q + 6'd1;
               state_d       = WAIT_FRAME;
            end else begin
               state_d = DRAW;
            end
         end
         WAIT_FRAME: begin
            if (frame_count_q == NUM_FRAMES) begin
               state_d = FINISH;
            end else if (frame_tick || tick_pending_q) begin
               state_d        = ERASE;
               tick_pending_d = 1'b0;
            end else begin
               state_d = WAIT_FRAME;
            end
         end
         ERASE: begin
            if (done_draw) begin
               state_d = MOVE;
            end else begin
               state_d = ERASE;
            end
         end
         MOVE: begin
            pos_x_d = move_x_s;
            state_d = DRAW;
            if (move_x_s == TURN_X) begin
               dir_left_d = 1'b1;
            end else if (move_x_s == START_X) begin
               dir_left_d = 1'b0;
            end else begin
               dir_left_d = dir_left_q;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; outputs are registered decodes of the upcoming state
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= IDLE;
         pos_x_q        <= START_X;
         dir_left_q     <= 1'b0;
         frame_count_q  <= 6'd0;
         tick_pending_q <= 1'b0;
         busy_q         <= 1'b0;
         enable_draw_q  <= 1'b0;
         enable_erase_q <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         pos_x_q        <= pos_x_d;
         dir_left_q     <= dir_left_d;
         frame_count_q  <= frame_count_d;
         tick_pending_q <= tick_pending_d;
         busy_q         <= (state_d != IDLE);
         enable_draw_q  <= (state_d == DRAW);
         enable_erase_q <= (state_d == ERASE);
         done_q         <= (state_d == FINISH);
      end
   end

   assign busy         = busy_q;
   assign enable_draw  = enable_draw_q;
   assign enable_erase = enable_erase_q;
   assign pos_x        = pos_x_q;
   assign pos_y        = START_Y;
   assign frame_count  = frame_count_q;
   assign done         = done_q;

endmodule
